// File: rtl/level_pkg.sv
// level_pkg: shared FSM states, LFSR constants and helpers for the level tester
package level_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int CNT_W = 8;
  localparam logic [7:0] TAP_MASK = 8'hB8;
  localparam logic [CNT_W-1:0] FIRST_FAIL_NONE = 8'hFF;
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & TAP_MASK)};
  endfunction
endpackage

// File: rtl/level_tester_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), zero seed replaced by 8'h01
module lfsr8 import level_pkg::*; #(
  parameter logic [7:0] INIT = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       shift,
  output logic       out_bit
);
  logic [7:0] lfsr, nxt;
  // next value: load wins over shift; out_bit is the MSB held after this edge
  always_comb begin
    nxt = load ? fix_seed(seed) : shift ? lfsr_step(lfsr) : lfsr;
    out_bit = nxt[7];
  end
  // shift register state
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= fix_seed(INIT);
    else lfsr <= nxt;
endmodule

// File: rtl/level_tester.sv
// level_tester: LFSR stimulus/identity-response checker with verdict; LEVEL_TESTER_STOP_ON_FAIL_EN ends a run at the first mismatch
module level_tester import level_pkg::*; #(
  parameter int         N_TESTS = 16,
  parameter int         LAT     = 0,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] test_idx,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx
);
  localparam int PD = (LAT > 0) ? LAT : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TESTS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_TESTS);
  state_t state, state_nxt;
  logic go, run, issue, lfsr_bit, exp_bit, cmp_en, miss, last_cmp, stop;
  logic [PD-1:0] pv, pb;
  logic [CNT_W-1:0] cmp_idx;
  lfsr8 #(.INIT(SEED)) u_lfsr (
    .clk(clk), .rst(rst), .load(go), .seed(SEED), .shift(issue), .out_bit(lfsr_bit)
  );
  // control decode, compare and next state; with LAT==0 resp is checked against live stim
  always_comb begin
    run = state == RUN;
    busy = run || state == DRAIN;
    done = state == DONE;
    pass = done && fail_count == '0;
    go = start && (state == IDLE || state == DONE);
    issue = run && test_idx != LAST;
    exp_bit = (LAT == 0) ? stim : pb[PD-1];
    cmp_en = busy && ((LAT == 0) || pv[PD-1]);
    miss = cmp_en && resp != exp_bit;
    last_cmp = cmp_en && cmp_idx == LAST;
`ifdef LEVEL_TESTER_STOP_ON_FAIL_EN
    stop = miss;
`else
    stop = 1'b0;
`endif
    state_nxt = go ? RUN
              : (busy && stop) ? DONE
              : (run && test_idx == LAST) ? ((LAT == 0) ? DONE : DRAIN)
              : (state == DRAIN && last_cmp) ? DONE
              : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // stimulus bit: follows the LFSR on issue, holds otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) stim <= 1'b0;
    else if (go || issue) stim <= lfsr_bit;
  // expected-bit pipeline, flushed whenever no run is active
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      pb <= '0;
    end else if (!busy) begin
      pv <= '0;
    end else begin
      pv <= PD'({pv, run});
      pb <= PD'({pb, stim});
    end
  // run counters and first-failure capture
  always_ff @(posedge clk or posedge rst)
    if (rst || go) begin
      test_idx <= '0;
      cmp_idx <= '0;
      fail_count <= '0;
      first_fail_idx <= FIRST_FAIL_NONE;
    end else begin
      if (run && test_idx != FULL) test_idx <= test_idx + 8'd1;
      if (cmp_en) cmp_idx <= cmp_idx + 8'd1;
      if (miss) fail_count <= fail_count + 8'd1;
      if (miss && fail_count == '0) first_fail_idx <= cmp_idx;
    end
endmodule

// File: tb/tb_level_tester.sv
// tb_level_tester: five level_tester instances around loopback, delay, inverter and noisy levels
module tb_level_tester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic err_cur = 1'b0;
  logic stim_w[5], resp_w[5], busy_w[5], done_w[5], pass_w[5];
  logic [7:0] tidx_w[5], fc_w[5], ff_w[5];
  logic [2:0] c1, c2;
  logic q4;
  int checks = 0;
  int failures = 0;
  int ns[5] = '{16, 16, 16, 16, 20};
  int ls[5] = '{0, 3, 2, 0, 1};
  logic [7:0] sd[5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
`ifdef LEVEL_TESTER_STOP_ON_FAIL_EN
  bit stop_mode = 1'b1;
`else
  bit stop_mode = 1'b0;
`endif
  typedef struct {
    string name;
    int done_at;
    int pass;
    int fc;
    int tidx;
    int ffi;
  } exp_t;
  exp_t tbl[5];
  int done_at[5];
  bit errs[20];

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) begin
      c1 <= '0;
      c2 <= '0;
      q4 <= 1'b0;
    end else begin
      c1 <= {c1[1:0], stim_w[1]};
      c2 <= {c2[1:0], stim_w[2]};
      q4 <= stim_w[4];
    end

  assign resp_w[0] = stim_w[0];
  assign resp_w[1] = c1[2];
  assign resp_w[2] = c2[2];
  assign resp_w[3] = ~stim_w[3];
  assign resp_w[4] = q4 ^ err_cur;

  level_tester #(.N_TESTS(16), .LAT(0), .SEED(8'hA5)) u0 (.clk(clk), .rst(rst), .start(start),
    .stim(stim_w[0]), .resp(resp_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .test_idx(tidx_w[0]), .fail_count(fc_w[0]), .first_fail_idx(ff_w[0]));
  level_tester #(.N_TESTS(16), .LAT(3), .SEED(8'hA5)) u1 (.clk(clk), .rst(rst), .start(start),
    .stim(stim_w[1]), .resp(resp_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .test_idx(tidx_w[1]), .fail_count(fc_w[1]), .first_fail_idx(ff_w[1]));
  level_tester #(.N_TESTS(16), .LAT(2), .SEED(8'hA5)) u2 (.clk(clk), .rst(rst), .start(start),
    .stim(stim_w[2]), .resp(resp_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .test_idx(tidx_w[2]), .fail_count(fc_w[2]), .first_fail_idx(ff_w[2]));
  level_tester #(.N_TESTS(16), .LAT(0), .SEED(8'hA5)) u3 (.clk(clk), .rst(rst), .start(start),
    .stim(stim_w[3]), .resp(resp_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
    .test_idx(tidx_w[3]), .fail_count(fc_w[3]), .first_fail_idx(ff_w[3]));
  level_tester #(.N_TESTS(20), .LAT(1), .SEED(8'h00)) u4 (.clk(clk), .rst(rst), .start(start),
    .stim(stim_w[4]), .resp(resp_w[4]), .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]),
    .test_idx(tidx_w[4]), .fail_count(fc_w[4]), .first_fail_idx(ff_w[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // bit 7 of the LFSR after k steps of x^8+x^6+x^5+x^4+1 from the seed
  function automatic bit vbit(input logic [7:0] seed, input int k);
    logic [7:0] s = (seed == 8'h00) ? 8'h01 : seed;
    for (int j = 0; j < k; j++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s[7];
  endfunction

  // verdict expected from the response each level gives to vector k
  function automatic exp_t model(input int i, input bit p2);
    exp_t e;
    int first = -1;
    int cnt = 0;
    for (int k = 0; k < ns[i]; k++) begin
      bit v = vbit(sd[i], k);
      bit r = (i == 2) ? ((k == 0) ? p2 : vbit(sd[i], k - 1))
            : (i == 3) ? ~v
            : (i == 4) ? (v ^ errs[k]) : v;
      if (r != v) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    e.name = $sformatf("inst%0d", i);
    e.done_at = (stop_mode && first >= 0) ? first + 1 + ls[i] : ns[i] + ls[i];
    e.fc = (stop_mode && first >= 0) ? 1 : cnt;
    e.pass = (cnt == 0) ? 1 : 0;
    e.ffi = (first < 0) ? 255 : first;
    e.tidx = (e.done_at < ns[i]) ? e.done_at : ns[i];
    return e;
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s.inst%0d.stim", tag, i), stim_w[i], 0);
      chk($sformatf("%s.inst%0d.busy", tag, i), busy_w[i], 0);
      chk($sformatf("%s.inst%0d.done", tag, i), done_w[i], 0);
      chk($sformatf("%s.inst%0d.pass", tag, i), pass_w[i], 0);
      chk($sformatf("%s.inst%0d.test_idx", tag, i), tidx_w[i], 0);
      chk($sformatf("%s.inst%0d.fail_count", tag, i), fc_w[i], 0);
      chk($sformatf("%s.inst%0d.first_fail_idx", tag, i), ff_w[i], 255);
    end
  endtask

  task automatic do_run(input bit [4:0] mask, input bit p2, input bit mid_start, input int abort_at);
    for (int k = 0; k < 20; k++) errs[k] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 5; i++) begin
      tbl[i] = model(i, p2);
      done_at[i] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      start = mid_start && c == 4;
      err_cur = (c >= 1 && c <= 20) ? errs[c - 1] : 1'b0;
      for (int i = 0; i < 5; i++)
        if (mask[i]) begin
          if (done_w[i] === 1'b1 && done_at[i] < 0) done_at[i] = c;
          chk($sformatf("inst%0d.busy@%0d", i, c), busy_w[i], c < tbl[i].done_at);
          if (c == 0) begin
            chk($sformatf("inst%0d.clr_test_idx", i), tidx_w[i], 0);
            chk($sformatf("inst%0d.clr_fail_count", i), fc_w[i], 0);
            chk($sformatf("inst%0d.clr_first_fail", i), ff_w[i], 255);
            chk($sformatf("inst%0d.clr_done", i), done_w[i], 0);
          end
        end
      if (mask[0] && c < 16) chk($sformatf("stim_a5@%0d", c), stim_w[0], vbit(8'hA5, c));
      if (mask[4] && c < 20 && c <= tbl[4].done_at)
        chk($sformatf("stim_seed0@%0d", c), stim_w[4], vbit(8'h01, c));
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        err_cur = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    err_cur = 1'b0;
    for (int i = 0; i < 5; i++)
      if (mask[i]) begin
        chk({tbl[i].name, ".done_at"}, done_at[i], tbl[i].done_at);
        chk({tbl[i].name, ".pass"}, pass_w[i], tbl[i].pass);
        chk({tbl[i].name, ".fail_count"}, fc_w[i], tbl[i].fc);
        chk({tbl[i].name, ".test_idx"}, tidx_w[i], tbl[i].tidx);
        chk({tbl[i].name, ".first_fail_idx"}, ff_w[i], tbl[i].ffi);
        chk({tbl[i].name, ".done_held"}, done_w[i], 1);
      end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    do_run(5'b11111, 1'b0, 1'b1, -1);
    do_run(5'b11011, 1'b0, 1'b0, -1);
    do_run(5'b11111, 1'b0, 1'b0, 7);
    do_run(5'b11111, 1'b0, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
